// File: rtl/core2uart_pkg.sv
// Shared types and helpers for the core-to-host result path: FSM state
// encoding, ASCII terminator bytes and the nibble-to-hex-character map.
package core2uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3,
    ST_WAIT = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with count-based full/empty flags.
// Writes are dropped when full and reads are ignored when empty.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/core2uart_tx.sv
// Buffers result words from the core and sends each as an ASCII message
// (prefix, uppercase hex MSB nibble first, optional CR LF) to uart_top.
module core2uart_tx
  import core2uart_pkg::*;
#(
  parameter int         DW         = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] PREFIX     = 8'h4E,
  parameter bit         USE_CRLF   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    tx_data,
  output logic          new_tx_data,
  input  logic          tx_busy,
  output logic          busy,
  output logic          msg_done,
  output state_e        dbg_state
);

  // Handshake: a word moves from the core when in_valid & in_ready are both
  // high on a clk edge; in_ready depends only on registered FIFO occupancy.

  localparam int NH = DW / 4;
  localparam int NB = 1 + NH + (USE_CRLF ? 2 : 0);
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  state_e        state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [DW-1:0] word_q, word_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          new_tx_q, new_tx_d;
  logic          msg_done_q, msg_done_d;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;
  logic [7:0]    cur_byte;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (in_data),
    .wr_en   (in_valid),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready    = ~fifo_full;
  assign busy        = (state != ST_IDLE) | ~fifo_empty;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign msg_done    = msg_done_q;
  assign dbg_state   = state;

  // Byte mux: index 0 is the prefix, then hex digits MSB nibble first,
  // then the optional terminator pair.
  always_comb begin
    cur_byte = PREFIX;
    for (int i = 1; i <= NH; i++) begin
      if (idx == IW'(i)) cur_byte = hex_ascii(word_q[4*(NH-i) +: 4]);
    end
    if (USE_CRLF && (idx == IW'(NH + 1))) cur_byte = ASCII_CR;
    if (USE_CRLF && (idx == IW'(NH + 2))) cur_byte = ASCII_LF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      new_tx_q   <= 1'b0;
      msg_done_q <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      new_tx_q   <= new_tx_d;
      msg_done_q <= msg_done_d;
    end
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    new_tx_d   = 1'b0;
    msg_done_d = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        word_d   = fifo_head;
        idx_d    = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_d = cur_byte;
          new_tx_d  = 1'b1;
          state_d   = ST_GAP;
        end
      end
      // uart_top raises tx_busy one cycle after the pulse, so it is not
      // trustworthy here.
      ST_GAP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            msg_done_d = 1'b1;
            state_d    = fifo_empty ? ST_IDLE : ST_LOAD;
          end else begin
            idx_d   = idx + IW'(1);
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core2uart_tx.sv
// Directed bench for core2uart_tx: default instance plus a 16-bit, no-CRLF
// instance, with a tx_busy model and a byte scoreboard.
module tb_core2uart_tx;
  import core2uart_pkg::*;

  localparam int NB = 11;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic        busy;
  logic        msg_done;
  state_e      dbg_state;

  logic [15:0] in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic [7:0]  tx_data2;
  logic        new_tx_data2;
  logic        tx_busy2;
  logic        busy2;
  logic        msg_done2;
  state_e      dbg_state2;

  logic        force_busy;
  int          busy_cnt;
  int          busy_len;

  logic [7:0]  exp_q[$];
  logic [7:0]  q2[$];
  int          n_vec;
  int          n_err;
  int          msg_byte_cnt;
  int          rx_cnt;
  int          done_cnt;
  int          done2;
  logic        b2b_watch;

  logic [7:0] t1_bytes [11] = '{8'h4E, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41,
                                8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
  logic [7:0] t5_bytes [5]  = '{8'h4E, 8'h42, 8'h45, 8'h45, 8'h46};

  assign tx_busy = force_busy || (busy_cnt != 0);

  core2uart_tx dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .msg_done    (msg_done),
    .dbg_state   (dbg_state)
  );

  core2uart_tx #(
    .DW       (16),
    .USE_CRLF (1'b0)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data2),
    .in_valid    (in_valid2),
    .in_ready    (in_ready2),
    .tx_data     (tx_data2),
    .new_tx_data (new_tx_data2),
    .tx_busy     (tx_busy2),
    .busy        (busy2),
    .msg_done    (msg_done2),
    .dbg_state   (dbg_state2)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic exp_msg(input logic [31:0] w);
    exp_q.push_back(8'h4E);
    for (int i = 7; i >= 0; i--) exp_q.push_back(asc(w[4*i +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_word(input logic [31:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max);
    check(tag, busy, 1'b0);
    @(negedge clk);
  endtask

  // Monitor, scoreboard and tx_busy model (check first, then update model)
  always @(negedge clk) begin
    if (rst) begin
      if (new_tx_data) begin
        check("idle_at_pulse", tx_busy, 1'b0);
        check("byte_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("byte", tx_data, exp_q.pop_front());
        msg_byte_cnt++;
        rx_cnt++;
      end
      if (msg_done) begin
        check("msg_len", msg_byte_cnt, NB);
        if (b2b_watch) begin
          check("b2b_state", dbg_state, ST_LOAD);
          b2b_watch = 1'b0;
        end
        msg_byte_cnt = 0;
        done_cnt++;
      end
      if (new_tx_data2) q2.push_back(tx_data2);
      if (msg_done2) done2++;
    end
    if (new_tx_data) busy_cnt = busy_len;
    else if (busy_cnt != 0) busy_cnt--;
  end

  initial begin
    int lat;
    int base;
    int d0;
    logic [31:0] w3 [6];
    n_vec = 0; n_err = 0; msg_byte_cnt = 0; rx_cnt = 0; done_cnt = 0; done2 = 0;
    b2b_watch = 1'b0; force_busy = 1'b0; busy_cnt = 0; busy_len = 10;
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    in_valid2 = 1'b0; in_data2 = '0; tx_busy2 = 1'b0;
    w3 = '{32'h11111111, 32'h22222222, 32'h33333333,
           32'h44444444, 32'h55555555, 32'h66666666};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_new_tx", new_tx_data, 1'b0);
    check("rst_msg_done", msg_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    @(negedge clk);

    // 1: single word, busy 10 cycles after each pulse, explicit byte list
    busy_len = 10;
    foreach (t1_bytes[i]) exp_q.push_back(t1_bytes[i]);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h1234ABCD;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (new_tx_data) lat = k;
    end
    check("t1_latency", lat, 3);
    wait_idle("t1_idle", 2000);
    check("t1_done", done_cnt, 1);
    check("t1_drained", exp_q.size(), 0);
    check("t1_tx_hold", tx_data, 8'h0A);

    // 2: two words back-to-back
    busy_len = 2;
    exp_msg(32'h00000000);
    exp_msg(32'hFFFFFFFF);
    b2b_watch = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00000000;
    @(negedge clk);
    in_data = 32'hFFFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("t2_idle", 2000);
    check("t2_done", done_cnt, 3);
    check("t2_b2b_seen", b2b_watch, 1'b0);
    check("t2_drained", exp_q.size(), 0);

    // 3: tx_busy stuck high, fill FIFO, then release
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_in_ready", in_ready, (i < 5) ? 1'b1 : 1'b0);
      in_valid = 1'b1;
      in_data  = w3[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_full_hold", in_ready, 1'b0);
    check("t3_stalled", dbg_state, ST_SEND);
    check("t3_no_pulse", rx_cnt, 33);
    for (int i = 0; i < 5; i++) exp_msg(w3[i]);
    force_busy = 1'b0;
    wait_idle("t3_idle", 4000);
    check("t3_done", done_cnt, 8);
    check("t3_drained", exp_q.size(), 0);

    // 4: reset after byte 5 of a message
    busy_len = 3;
    base = rx_cnt;
    d0 = done_cnt;
    exp_msg(32'hCAFE0123);
    push_word(32'hCAFE0123);
    for (int k = 0; k < 500 && rx_cnt < base + 5; k++) begin
      @(negedge clk);
      #1;
    end
    check("t4_reached_b5", rx_cnt, base + 5);
    check("t4_pre_pulse", new_tx_data, 1'b1);
    rst = 1'b0;
    #1;
    check("t4_new_tx", new_tx_data, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_in_ready", in_ready, 1'b1);
    check("t4_tx_data", tx_data, 8'h00);
    exp_q.delete();
    msg_byte_cnt = 0;
    busy_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_msg(32'h00C0FFEE);
    push_word(32'h00C0FFEE);
    wait_idle("t4_idle", 2000);
    check("t4_done", done_cnt, d0 + 1);
    check("t4_drained", exp_q.size(), 0);

    // 5: 16-bit word, no terminator (second instance)
    @(negedge clk);
    in_valid2 = 1'b1; in_data2 = 16'hBEEF;
    @(negedge clk);
    in_valid2 = 1'b0;
    for (int k = 0; k < 200 && (busy2 || done2 == 0); k++) @(negedge clk);
    @(negedge clk);
    check("t5_count", q2.size(), 5);
    foreach (t5_bytes[i]) check("t5_byte", (q2.size() > i) ? q2[i] : 8'hXX, t5_bytes[i]);
    check("t5_done", done2, 1);

    // 6: minimum one-cycle tx_busy after each pulse
    busy_len = 1;
    d0 = done_cnt;
    exp_msg(32'h89ABCDEF);
    exp_msg(32'h76543210);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h89ABCDEF;
    @(negedge clk);
    in_data = 32'h76543210;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("t6_idle", 2000);
    check("t6_done", done_cnt, d0 + 2);
    check("t6_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
